// File: rtl/booth_mult_datapath_pkg.sv
// Shared widths, iteration bounds and FSM encoding for the radix-4 Booth
// multiplier datapath.
package booth_mult_datapath_pkg;

    localparam int          WIDTH      = 32;
    localparam int          ACC_WIDTH  = 34;
    localparam int          ITERATIONS = 16;
    localparam logic [3:0]  LAST_COUNT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/booth_mult_datapath_addend.sv
// Booth addend selection (0, M or 2M, sign-extended) and the accumulator
// add/subtract for one radix-4 iteration.
module booth_addend_sel
    import booth_mult_datapath_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic signed [WIDTH-1:0]     mcand,
    input  logic                        times_two,
    input  logic                        sub,
    input  logic                        zero,
    output logic signed [ACC_WIDTH-1:0] acc_next
);

    logic signed [ACC_WIDTH-1:0] m_ext;
    logic signed [ACC_WIDTH-1:0] addend;

    always_comb begin
        m_ext = ACC_WIDTH'(mcand);
        if (zero) begin
            addend = '0;
        end else if (times_two) begin
            addend = m_ext <<< 1;
        end else begin
            addend = m_ext;
        end
        acc_next = sub ? (acc - addend) : (acc + addend);
    end

endmodule

// File: rtl/booth_mult_datapath.sv
// Radix-4 Booth multiplier datapath: 16 add/shift iterations steered by an
// external Booth control unit; produces the low 32 product bits plus overflow.
module booth_mult_datapath
    import booth_mult_datapath_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] multiplicand,
    input  logic signed [WIDTH-1:0] multiplier,
    input  logic                    multiTimesTwo,
    input  logic                    addOrSub,
    input  logic                    result_or_zero,
    input  logic [3:0]              count,
    output logic [2:0]              lowBits,
    output logic                    ctrl_reset,
    output logic                    busy,
    output logic                    result_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    overflow
);

    localparam int CAT_W = ACC_WIDTH + WIDTH + 1;

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] a_q, a_d;
    logic signed [WIDTH-1:0]     q_q, q_d;
    logic                        qm1_q, qm1_d;
    logic signed [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]            result_q, result_d;
    logic                        overflow_q, overflow_d;

    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [CAT_W-1:0]            cat_w;
    logic [CAT_W-1:0]            shr_w;

    booth_addend_sel u_addend_sel (
        .acc       (a_q),
        .mcand     (m_q),
        .times_two (multiTimesTwo),
        .sub       (addOrSub),
        .zero      (result_or_zero),
        .acc_next  (acc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The external counter runs only in RUN, so count==LAST_COUNT marks the 16th edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (count == LAST_COUNT) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl_reset   = (state_q != ST_RUN);
        busy         = (state_q != ST_IDLE);
        result_ready = (state_q == ST_DONE);
    end

    // {A', Q, q_m1} arithmetic shift right by two, sign taken from A'.
    always_comb begin
        cat_w = {acc_next, q_q, qm1_q};
        shr_w = {{2{cat_w[CAT_W-1]}}, cat_w[CAT_W-1:2]};
    end

    always_comb begin
        a_d        = a_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        m_d        = m_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d   = '0;
                    q_d   = multiplier;
                    qm1_d = 1'b0;
                    m_d   = multiplicand;
                end
            end
            ST_RUN: begin
                a_d   = shr_w[CAT_W-1:WIDTH+1];
                q_d   = shr_w[WIDTH:1];
                qm1_d = shr_w[0];
                if (count == LAST_COUNT) begin
                    result_d   = shr_w[WIDTH:1];
                    overflow_d = (shr_w[CAT_W-1:WIDTH+1] != {ACC_WIDTH{shr_w[WIDTH]}});
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            q_q        <= '0;
            qm1_q      <= 1'b0;
            m_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            q_q        <= q_d;
            qm1_q      <= qm1_d;
            m_q        <= m_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign lowBits  = {q_q[1:0], qm1_q};
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_booth_mult_datapath.sv
// Bench for booth_mult_datapath: models the external Booth control unit and
// counter, and checks the datapath against plain 64-bit signed multiplication.
module tb_booth_mult_datapath;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        multiTimesTwo;
    logic        addOrSub;
    logic        result_or_zero;
    logic [3:0]  count;
    logic [2:0]  lowBits;
    logic        ctrl_reset;
    logic        busy;
    logic        result_ready;
    logic [31:0] result;
    logic        overflow;

    int vectors;
    int miscompares;

    booth_mult_datapath dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .multiTimesTwo  (multiTimesTwo),
        .addOrSub       (addOrSub),
        .result_or_zero (result_or_zero),
        .count          (count),
        .lowBits        (lowBits),
        .ctrl_reset     (ctrl_reset),
        .busy           (busy),
        .result_ready   (result_ready),
        .result         (result),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External Booth control unit: radix-4 recoding of lowBits plus iteration counter.
    assign multiTimesTwo  = (lowBits == 3'b011) || (lowBits == 3'b100);
    assign addOrSub       = lowBits[2];
    assign result_or_zero = (lowBits == 3'b000) || (lowBits == 3'b111);

    logic [3:0] cnt_q;
    always @(posedge clk or posedge reset) begin
        if (reset)           cnt_q <= 4'd0;
        else if (ctrl_reset) cnt_q <= 4'd0;
        else                 cnt_q <= cnt_q + 4'd1;
    end
    assign count = cnt_q;

    // Behavioural model: phase 0 idle, 1..16 iterating, 17 result cycle.
    int                 ph;
    logic signed [31:0] op_m, op_q;
    logic signed [63:0] prod;
    logic [31:0]        exp_res;
    logic               exp_ovf;

    assign prod = 64'(op_m) * 64'(op_q);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph      <= 0;
            exp_res <= 32'd0;
            exp_ovf <= 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph   <= 1;
                op_m <= multiplicand;
                op_q <= multiplier;
            end
        end else if (ph == 16) begin
            ph      <= 17;
            exp_res <= prod[31:0];
            exp_ovf <= (prod != {{32{prod[31]}}, prod[31:0]});
        end else if (ph == 17) begin
            ph <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(ph != 0));
        check("result_ready", 64'(result_ready), 64'(ph == 17));
        check("ctrl_reset", 64'(ctrl_reset), 64'(ph == 0 || ph == 17));
        if (ph == 0 || ph == 17) begin
            check("result_hold", 64'(result), 64'(exp_res));
            check("overflow_hold", 64'(overflow), 64'(exp_ovf));
        end
    end

    // Drive one operation; poke_at >= 0 re-asserts start with other operands mid-run.
    task automatic run_op(input string name, input logic [31:0] m, input logic [31:0] q,
                          input logic [31:0] want_r, input logic want_o, input int poke_at);
        int n;
        @(posedge clk); #1;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        n = 0;
        while (!result_ready && n < 40) begin
            if (n == poke_at) begin
                start        = 1'b1;
                multiplicand = 32'd99;
                multiplier   = 32'd99;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(n), 64'd16);
        check({name, "_result"}, 64'(result), 64'(want_r));
        check({name, "_overflow"}, 64'(overflow), 64'(want_o));
        check({name, "_model_result"}, 64'(exp_res), 64'(want_r));
        check({name, "_model_overflow"}, 64'(exp_ovf), 64'(want_o));
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(result_ready), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_ctrl_reset", 64'(ctrl_reset), 64'd1);
        check("rst_lowbits", 64'(lowBits), 64'd0);

        run_op("3x5",       32'd3,          32'd5,          32'd15,         1'b0, -1);
        run_op("m7x6",      32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6,  1'b0, -1);
        run_op("m1xm1",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, -1);
        run_op("max_x2",    32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, -1);
        run_op("min_xm1",   32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, -1);
        run_op("min_xmin",  32'h8000_0000,  32'h8000_0000,  32'd0,          1'b1, -1);
        run_op("zero_x",    32'd0,          32'd12345,      32'd0,          1'b0, -1);
        run_op("restart",   32'd1234,       32'hFFFF_FFFD,  32'hFFFF_F18A,  1'b0, 5);

        // Abort an operation partway through with reset.
        @(posedge clk); #1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_ready", 64'(result_ready), 64'd0);
        check("abort_overflow", 64'(overflow), 64'd0);
        #3;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_idle", 64'(busy), 64'd0);

        run_op("4x4",       32'd4,          32'd4,          32'd16,         1'b0, -1);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_mult_datapath.md
BOOTH_MULT_DATAPATH -- requirements
Module: booth_mult_datapath

Interface
REQ-001 SHALL have one clock and reset: asynchronous, active-high.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 start  in  1  request a multiply; sampled only in IDLE.
REQ-005 multiplicand  in  32  signed operand M; captured on accepted start.
REQ-006 multiplier  in  32  signed operand Q; captured on accepted start.
REQ-007 multiTimesTwo  in  1  from Booth control unit: addend is 2M, not M.
REQ-008 addOrSub  in  1  from Booth control unit: 1 = subtract addend, 0 = add.
REQ-009 result_or_zero  in  1  from Booth control unit: 1 = addend is zero.
REQ-010 count  in  4  iteration count from the control-unit counter.
REQ-011 lowBits  out  3  {Q[1], Q[0], q_m1} fed to the Booth control unit.
REQ-012 ctrl_reset  out  1  holds the control-unit counter at 0.
REQ-013 busy  out  1  high while not IDLE.
REQ-014 result_ready  out  1  one-cycle pulse when result is valid.
REQ-015 result  out  32  low 32 bits of signed product.
REQ-016 overflow  out  1  product does not fit in signed 32 bits.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 IDLE with start=1 at an edge SHALL load A=0 (34 bits), Q=multiplier, q_m1=0, M=multiplicand, and go to RUN.
REQ-019 start in RUN or DONE SHALL be ignored; no operand capture.
REQ-020 ctrl_reset SHALL be combinationally high in IDLE and DONE, low in RUN, so count=0 in the first RUN cycle.
REQ-021 Each RUN edge SHALL build addend = 0 if result_or_zero, else sign-extended (M<<1 if multiTimesTwo else M) to 34 bits.
REQ-022 Each RUN edge SHALL compute A' = A - addend if addOrSub, else A + addend, in 34-bit two's complement.
REQ-023 Each RUN edge SHALL then arithmetic-shift {A', Q, q_m1} right by 2, sign-filling from A'[33].
REQ-024 A RUN edge with count==15 SHALL do the 16th iteration and go to DONE; exactly 16 iterations per operation.
REQ-025 result_ready SHALL be high only during the single DONE cycle, i.e. the cycle after the 16th edge after the start edge.
REQ-026 result SHALL equal final Q and hold from DONE until the next accepted start.
REQ-027 overflow SHALL be 1 iff final A[33:0] is not all equal to final Q[31]; it holds like result.
REQ-028 lowBits SHALL reflect current registers combinationally in every state.
REQ-029 DONE SHALL return to IDLE unconditionally after one cycle.

Reset
REQ-030 reset SHALL asynchronously force IDLE and set A, Q, q_m1, M, result, overflow, and result_ready to 0.
REQ-031 reset mid-RUN SHALL abort the operation; result_ready SHALL NOT pulse for it.
REQ-032 After reset release, the first start SHALL behave identically to power-on.

Structure
REQ-033 A shared package SHALL hold WIDTH=32, ACC_WIDTH=34, ITERATIONS=16, LAST_COUNT=4'd15, and the FSM state enum.
REQ-034 One sub-module booth_addend_sel SHALL contain the combinational addend select and add/sub (REQ-021, REQ-022).
REQ-035 The Booth control unit SHALL remain external; this block consumes its outputs and drives its lowBits and counter reset.

Verification
REQ-036 Bench SHALL model the control unit and counter and cover these cases.
REQ-037 Case 1: 3 x 5 -> result=15, overflow=0, result_ready 16 edges after the start edge.
REQ-038 Case 2: -7 x 6 -> result=0xFFFFFFD6 (-42), overflow=0; also -1 x -1 -> result=1, overflow=0.
REQ-039 Case 3: 0x7FFFFFFF x 2 -> result=0xFFFFFFFE, overflow=1.
REQ-040 Case 4: 0x80000000 x 0xFFFFFFFF -> result=0x80000000, overflow=1.
REQ-041 Case 5: start re-asserted with new operands during RUN -> ignored; the first product completes unchanged.
REQ-042 Case 6: reset at iteration 8 -> busy=0, result=0, no result_ready; then 4 x 4 -> 16.
